fifo_rd_ptr_empty_ctrl: RTL and testbench

Read-side control stage for the dual-clock FIFO. It drives rd_addr into the FIFO memory and owns the read pointer. It synchronises the write-domain Gray pointer into rd_clk and generates registered empty, almost-empty, fill level and underflow indications. It sits directly upstream of the memory's read port and entirely in the read clock domain.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_sync_stage.sv | 37 +++
 rtl/fifo_rd_ptr_empty_ctrl.sv | 102 ++++++++++
 tb/tb_fifo_rd_ptr_empty_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Helpers and constants shared by the read-pointer/empty and the
// write-pointer/full control blocks of the dual-clock FIFO.
//   bin2gray / gray2bin : pointer code conversions. Operands are handled at
//                         FuncWidth bits; callers zero-extend narrower
//                         pointers and truncate the result back, which is
//                         exact for any pointer width up to FuncWidth.
//   PtrWidth / Depth    : pointer width and memory depth for the default
//                         address width.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FuncWidth           = 32;
    localparam int DefaultAddressWidth = 4;
    localparam int PtrWidth            = DefaultAddressWidth + 1;
    localparam int Depth               = 1 << DefaultAddressWidth;

    function automatic logic [FuncWidth-1:0] bin2gray(input logic [FuncWidth-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero bits above the real pointer width leave the lower bits untouched,
    // since each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FuncWidth-1:0] gray2bin(input logic [FuncWidth-1:0] g);
        logic [FuncWidth-1:0] b;
        b[FuncWidth-1] = g[FuncWidth-1];
        for (int i = FuncWidth - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_stage.sv
// ---------------------------------------------------------------------------
// fifo_sync_stage
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Used for both the write-to-read and the read-to-write pointer crossings.
//   clk_i  : destination-domain clock
//   rst_ni : asynchronous active-low reset, clears every stage
//   d_i    : Width-bit Gray value from the source domain (no logic in front)
//   q_o    : synchronised value, Stages clk_i edges after d_i settles
// ---------------------------------------------------------------------------
module fifo_sync_stage #(
    parameter int Width  = 5,
    parameter int Stages = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] sync_q [Stages];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Stages; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < Stages; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/fifo_rd_ptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ptr_empty_ctrl
// Read-side control of the dual-clock FIFO: owns the read pointer, drives
// the memory read address and derives registered empty / almost-empty /
// level / underflow from the synchronised write pointer.
//   rd_clk, rd_rst_n  : read clock, asynchronous active-low reset
//   rd_req            : pop request, honoured only while rd_empty=0
//   wr_ptr_gray       : Gray write pointer from the write domain
//   rd_addr           : memory read address (low bits of binary read ptr)
//   rd_ptr_gray       : registered Gray read pointer for the write domain
//   rd_empty          : registered empty flag
//   rd_almost_empty   : registered, level <= AlmostEmptyThreshold
//   rd_level          : registered occupancy seen from the read side
//   rd_underflow      : one-cycle pulse for a pop request while empty
// ---------------------------------------------------------------------------
module fifo_rd_ptr_empty_ctrl #(
    parameter int AddressWidth         = 4,
    parameter int AlmostEmptyThreshold = 2,
    parameter int SyncStages           = 2
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst_n,
    input  logic                    rd_req,
    input  logic [AddressWidth:0]   wr_ptr_gray,
    output logic [AddressWidth-1:0] rd_addr,
    output logic [AddressWidth:0]   rd_ptr_gray,
    output logic                    rd_empty,
    output logic                    rd_almost_empty,
    output logic [AddressWidth:0]   rd_level,
    output logic                    rd_underflow
);

    import fifo_pkg::*;

    localparam int PtrW = AddressWidth + 1;
    localparam logic [PtrW-1:0] AeThreshold = PtrW'(AlmostEmptyThreshold);

    logic [PtrW-1:0] wr_gray_sync;
    logic [PtrW-1:0] wr_bin_sync;

    logic [PtrW-1:0] rd_bin_q,   rd_bin_d;
    logic [PtrW-1:0] rd_gray_q,  rd_gray_d;
    logic [PtrW-1:0] rd_level_q, rd_level_d;
    logic            rd_empty_q, rd_empty_d;
    logic            rd_aempty_q, rd_aempty_d;
    logic            rd_uflow_q, rd_uflow_d;
    logic            rd_inc;

    fifo_sync_stage #(
        .Width  (PtrW),
        .Stages (SyncStages)
    ) u_wr_ptr_sync (
        .clk_i  (rd_clk),
        .rst_ni (rd_rst_n),
        .d_i    (wr_ptr_gray),
        .q_o    (wr_gray_sync)
    );

    always_comb begin
        rd_inc      = rd_req & ~rd_empty_q;
        rd_bin_d    = rd_bin_q + PtrW'(rd_inc);
        rd_gray_d   = PtrW'(bin2gray(32'(rd_bin_d)));
        wr_bin_sync = PtrW'(gray2bin(32'(wr_gray_sync)));
        // Compare against the post-pop pointer so the pop that drains the
        // last word raises empty on the very next cycle. The full-width
        // Gray compare keeps the wrap bit, so full never aliases empty.
        rd_empty_d  = (rd_gray_d == wr_gray_sync);
        // Modulo subtraction stays correct across pointer wrap; the synced
        // write pointer lags, so the level can only under-report.
        rd_level_d  = wr_bin_sync - rd_bin_d;
        rd_aempty_d = (rd_level_d <= AeThreshold);
        rd_uflow_d  = rd_req & rd_empty_q;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            rd_level_q  <= '0;
            rd_empty_q  <= 1'b1;
            rd_aempty_q <= 1'b1;
            rd_uflow_q  <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            rd_level_q  <= rd_level_d;
            rd_empty_q  <= rd_empty_d;
            rd_aempty_q <= rd_aempty_d;
            rd_uflow_q  <= rd_uflow_d;
        end
    end

    // The address comes straight from the pointer register, so it is valid
    // in the same cycle that rd_empty drops (first-word fall-through).
    assign rd_addr         = rd_bin_q[AddressWidth-1:0];
    assign rd_ptr_gray     = rd_gray_q;
    assign rd_empty        = rd_empty_q;
    assign rd_almost_empty = rd_aempty_q;
    assign rd_level        = rd_level_q;
    assign rd_underflow    = rd_uflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_empty_ctrl.sv
module tb_fifo_rd_ptr_empty_ctrl;

    localparam int AW = 2;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n;
    logic          rd_req;
    logic [AW:0]   wr_ptr_gray;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rd_ptr_gray;
    logic          rd_empty;
    logic          rd_almost_empty;
    logic [AW:0]   rd_level;
    logic          rd_underflow;

    int errors = 0;
    int checks = 0;

    fifo_rd_ptr_empty_ctrl #(
        .AddressWidth         (AW),
        .AlmostEmptyThreshold (2),
        .SyncStages           (2)
    ) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .rd_req          (rd_req),
        .wr_ptr_gray     (wr_ptr_gray),
        .rd_addr         (rd_addr),
        .rd_ptr_gray     (rd_ptr_gray),
        .rd_empty        (rd_empty),
        .rd_almost_empty (rd_almost_empty),
        .rd_level        (rd_level),
        .rd_underflow    (rd_underflow)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [2:0] wr;
        logic       req;
        logic [1:0] addr;
        logic [2:0] pg;
        logic       empty;
        logic       ae;
        logic [2:0] level;
        logic       uf;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];
    vec_t exp_q [$];
    vec_t rst_v;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".addr"},  8'(rd_addr),         8'(e.addr));
        chk({tag, ".pgray"}, 8'(rd_ptr_gray),     8'(e.pg));
        chk({tag, ".empty"}, 8'(rd_empty),        8'(e.empty));
        chk({tag, ".aempt"}, 8'(rd_almost_empty), 8'(e.ae));
        chk({tag, ".level"}, 8'(rd_level),        8'(e.level));
        chk({tag, ".uflow"}, 8'(rd_underflow),    8'(e.uf));
    endtask

    initial begin
        //          wr      req   addr  pg      emp   ae    lvl   uf
        vecs[0]  = '{3'b001, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[1]  = '{3'b001, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[2]  = '{3'b001, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[3]  = '{3'b110, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[4]  = '{3'b110, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[5]  = '{3'b110, 1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 3'd4, 1'b0};
        vecs[6]  = '{3'b110, 1'b1, 2'd1, 3'b001, 1'b0, 1'b0, 3'd3, 1'b0};
        vecs[7]  = '{3'b110, 1'b1, 2'd2, 3'b011, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[8]  = '{3'b110, 1'b1, 2'd3, 3'b010, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[9]  = '{3'b110, 1'b1, 2'd0, 3'b110, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[10] = '{3'b110, 1'b1, 2'd0, 3'b110, 1'b1, 1'b1, 3'd0, 1'b1};
        vecs[11] = '{3'b110, 1'b1, 2'd0, 3'b110, 1'b1, 1'b1, 3'd0, 1'b1};
        vecs[12] = '{3'b110, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[13] = '{3'b100, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[14] = '{3'b100, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[15] = '{3'b100, 1'b0, 2'd0, 3'b110, 1'b0, 1'b0, 3'd3, 1'b0};
        vecs[16] = '{3'b100, 1'b1, 2'd1, 3'b111, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[17] = '{3'b100, 1'b1, 2'd2, 3'b101, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[18] = '{3'b100, 1'b1, 2'd3, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[19] = '{3'b000, 1'b0, 2'd3, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[20] = '{3'b000, 1'b0, 2'd3, 3'b100, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[21] = '{3'b000, 1'b0, 2'd3, 3'b100, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[22] = '{3'b000, 1'b1, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[23] = '{3'b000, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[24] = '{3'b011, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[25] = '{3'b011, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[26] = '{3'b011, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[27] = '{3'b110, 1'b1, 2'd1, 3'b001, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[28] = '{3'b110, 1'b1, 2'd2, 3'b011, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[29] = '{3'b110, 1'b1, 2'd2, 3'b011, 1'b0, 1'b1, 3'd2, 1'b1};
        vecs[30] = '{3'b110, 1'b1, 2'd3, 3'b010, 1'b0, 1'b1, 3'd1, 1'b0};
        vecs[31] = '{3'b110, 1'b0, 2'd3, 3'b010, 1'b0, 1'b1, 3'd1, 1'b0};
        rst_v    = '{3'b000, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0};

        // Reset with a non-zero write pointer, then release.
        rd_rst_n    = 1'b0;
        rd_req      = 1'b0;
        wr_ptr_gray = 3'b011;
        #12;
        chk_all("rst_hold", rst_v);
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        @(posedge rd_clk); #1;
        @(posedge rd_clk); #1;
        chk("rel_edge2.empty", 8'(rd_empty), 8'd1);
        @(posedge rd_clk); #1;
        chk("rel_edge3.empty", 8'(rd_empty), 8'd0);
        chk("rel_edge3.level", 8'(rd_level), 8'd2);
        chk("rel_edge3.aempt", 8'(rd_almost_empty), 8'd1);

        // Fresh reset with the write pointer at zero for the vector table.
        @(negedge rd_clk);
        rd_rst_n    = 1'b0;
        wr_ptr_gray = 3'b000;
        #1;
        chk_all("rst2", rst_v);
        @(negedge rd_clk);
        rd_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge rd_clk);
            wr_ptr_gray = vecs[i].wr;
            rd_req      = vecs[i].req;
            exp_q.push_back(vecs[i]);
            @(posedge rd_clk); #1;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: queue empty at row %0d", i);
            end else begin
                chk_all($sformatf("row%0d", i), exp_q.pop_front());
            end
        end

        // Raise the level to 3 (write pointer binary 6, read pointer 3).
        @(negedge rd_clk);
        rd_req      = 1'b0;
        wr_ptr_gray = 3'b101;
        repeat (3) @(posedge rd_clk);
        #1;
        chk("pre_arst.level", 8'(rd_level), 8'd3);

        // Half-cycle asynchronous reset pulse placed between clock edges.
        #2;
        rd_rst_n    = 1'b0;
        wr_ptr_gray = 3'b000;
        #1;
        chk_all("arst", rst_v);
        #3;
        rd_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge rd_clk); #1;
            chk($sformatf("post_arst%0d.empty", k), 8'(rd_empty), 8'd1);
            chk($sformatf("post_arst%0d.level", k), 8'(rd_level), 8'd0);
            chk($sformatf("post_arst%0d.pgray", k), 8'(rd_ptr_gray), 8'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
